rf_wb_arbiter: RTL

- Write-side front end of the 32x32 register file. It merges two write sources into the single register-file write port (write enable, 5-bit address, 32-bit data):
  - the in-order pipeline writeback;
  - a long-latency unit (mul/div, uncached load) using a valid/ready handshake.
- Long-latency results are buffered in a small FIFO.
- A busy scoreboard lets decode stall on registers whose results are still outstanding.

---
 rtl/rf_wb_if.sv | 35 +++
 rtl/rf_wb_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rf_wb_if.sv
// Write-side bus between the decode/pipeline/long-latency unit and rf_wb_arbiter.
// DEPTH sizes fifo_count and must match the arbiter's DEPTH.
interface rf_wb_if #(
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          pipe_wr;
   logic [4:0]    pipe_addr;
   logic [31:0]   pipe_data;
   logic          lu_valid;
   logic          lu_ready;
   logic [4:0]    lu_addr;
   logic [31:0]   lu_data;
   logic          issue_valid;
   logic [4:0]    issue_addr;
   logic [31:0]   busy_mask;
   logic          stall_req;
   logic          rf_wr;
   logic [4:0]    rf_addr;
   logic [31:0]   rf_data;
   logic [CW-1:0] fifo_count;

   modport master (
      output pipe_wr, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
             issue_valid, issue_addr,
      input  lu_ready, busy_mask, stall_req, rf_wr, rf_addr, rf_data, fifo_count
   );

   modport slave (
      input  pipe_wr, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
             issue_valid, issue_addr,
      output lu_ready, busy_mask, stall_req, rf_wr, rf_addr, rf_data, fifo_count
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Merges pipeline writeback and buffered long-latency results onto the register-file write port.
// Optional WB_BYPASS_EN: an accepted result into an empty, uncontended FIFO goes straight to rf_*.
module rf_wb_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic    clk,
   input  logic    reset,
   rf_wb_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          stall_q, stall_d;
   logic [31:0]   busy_q, busy_d;
   logic          rf_wr_q, rf_wr_d;
   logic [4:0]    rf_addr_q, rf_addr_d;
   logic [31:0]   rf_data_q, rf_data_d;

   logic pipe_eff, empty, lu_ready_c, lu_xfer, bypass, push, pop;
   logic [4:0]  head_addr;
   logic [31:0] head_data;

   assign pipe_eff   = bus.pipe_wr && (bus.pipe_addr != 5'd0);
   assign empty      = (count_q == '0);
   assign lu_ready_c = (count_q < CW'(DEPTH));
   assign lu_xfer    = bus.lu_valid && lu_ready_c;
   assign head_addr  = mem_addr[rd_ptr_q];
   assign head_data  = mem_data[rd_ptr_q];

`ifdef WB_BYPASS_EN
   assign bypass = empty && !pipe_eff && lu_xfer && (bus.lu_addr != 5'd0);
`else
   assign bypass = 1'b0;
`endif

   // $0 results are accepted but never stored; the pipeline always has priority over a pop.
   assign push = lu_xfer && (bus.lu_addr != 5'd0) && !bypass;
   assign pop  = !pipe_eff && !empty;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      starve_d  = starve_q;
      busy_d    = busy_q;
      rf_wr_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Counter saturates at the limit; any pop or an empty FIFO restarts it.
      if (pop || empty)
         starve_d = '0;
      else if (starve_q < SW'(STARVE_LIMIT))
         starve_d = starve_q + SW'(1);

      if (pipe_eff) begin
         rf_wr_d   = 1'b1;
         rf_addr_d = bus.pipe_addr;
         rf_data_d = bus.pipe_data;
      end else if (bypass) begin
         rf_wr_d   = 1'b1;
         rf_addr_d = bus.lu_addr;
         rf_data_d = bus.lu_data;
      end else if (pop) begin
         rf_wr_d   = 1'b1;
         rf_addr_d = head_addr;
         rf_data_d = head_data;
      end

      // Clears are applied before the set so a same-cycle reissue keeps the register busy.
      if (pop)    busy_d[head_addr]   = 1'b0;
      if (bypass) busy_d[bus.lu_addr] = 1'b0;
      if (bus.issue_valid && (bus.issue_addr != 5'd0)) busy_d[bus.issue_addr] = 1'b1;
      busy_d[0] = 1'b0;

      stall_d = (starve_d >= SW'(STARVE_LIMIT));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         starve_q  <= '0;
         stall_q   <= 1'b0;
         busy_q    <= '0;
         rf_wr_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
         busy_q    <= busy_d;
         rf_wr_q   <= rf_wr_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   // Storage is not reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_addr[wr_ptr_q] <= bus.lu_addr;
         mem_data[wr_ptr_q] <= bus.lu_data;
      end
   end

   assign bus.lu_ready   = lu_ready_c;
   assign bus.busy_mask  = busy_q;
   assign bus.stall_req  = stall_q;
   assign bus.rf_wr      = rf_wr_q;
   assign bus.rf_addr    = rf_addr_q;
   assign bus.rf_data    = rf_data_q;
   assign bus.fifo_count = count_q;
endmodule
